// File: rtl/phy_tx_frame_builder.sv
// PD PHY transmit framer: preamble, SOP K-codes, 4b5b payload, CRC and EOP as 5-bit symbols.
// Define PHY_TX_BIST_EN to enable BIST carrier mode (phy_tx_bist_en holds the preamble).
module phy_tx_frame_builder #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CRC_NIB = 8,
  parameter int unsigned MAX_NIB = 60
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              phy_tx_packet_en,
  input  logic [2:0]        phy_tx_packet_type,
  input  logic              phy_tx_abort,
  input  logic [DATA_W-1:0] pl2phy_tx_payload,
  input  logic              pl2phy_tx_payload_last,
  output logic              phy2pl_tx_payload_done,
  input  logic [31:0]       phy_tx_packet_crc,
  input  logic              phy_tx_bist_en,
  output logic              phy_bmc_encoder_data_en,
  output logic [4:0]        phy_bmc_encoder_data,
  output logic              phy_bmc_encoder_data_preamble,
  input  logic              phy_bmc_encoder_data_done,
  input  logic              phy_bmc_encoder_hold_lowbmc_done,
  output logic              phy_tx_done,
  output logic              phy_tx_err
);

  localparam int unsigned NPW     = DATA_W / 4;
  localparam int unsigned SymSpan = (CRC_NIB > 4) ? ((CRC_NIB > NPW) ? CRC_NIB : NPW)
                                                  : ((NPW > 4) ? NPW : 4);
  localparam int unsigned SymW    = $clog2(SymSpan);
  localparam int unsigned NibW    = $clog2(MAX_NIB + 1);
  localparam int unsigned NpwW    = (NPW > 1) ? $clog2(NPW) : 1;

  localparam logic [4:0] SymS1  = 5'b11000;
  localparam logic [4:0] SymS2  = 5'b10001;
  localparam logic [4:0] SymS3  = 5'b00110;
  localparam logic [4:0] SymR1  = 5'b00111;
  localparam logic [4:0] SymR2  = 5'b11001;
  localparam logic [4:0] SymEop = 5'b01101;

  typedef enum logic [2:0] {
    StIdle,
    StPreamble,
    StSop,
    StPayload,
    StCrc,
    StEop,
    StHold
  } state_e;

  function automatic logic [4:0] enc_4b5b(input logic [3:0] nib);
    logic [4:0] code;
    case (nib)
      4'h0:    code = 5'b11110;
      4'h1:    code = 5'b01001;
      4'h2:    code = 5'b10100;
      4'h3:    code = 5'b10101;
      4'h4:    code = 5'b01010;
      4'h5:    code = 5'b01011;
      4'h6:    code = 5'b01110;
      4'h7:    code = 5'b01111;
      4'h8:    code = 5'b10010;
      4'h9:    code = 5'b10011;
      4'hA:    code = 5'b10110;
      4'hB:    code = 5'b10111;
      4'hC:    code = 5'b11010;
      4'hD:    code = 5'b11011;
      4'hE:    code = 5'b11100;
      default: code = 5'b11101;
    endcase
    return code;
  endfunction

  // K-code sequence per ordered set; first symbol sits in the top five bits.
  function automatic logic [4:0] sop_sym(input logic [2:0] ptype, input logic [1:0] idx);
    logic [19:0] seq;
    case (ptype)
      3'd1:    seq = {SymS1, SymS1, SymS3, SymS3};
      3'd2:    seq = {SymS1, SymS3, SymS1, SymS3};
      3'd3:    seq = {SymR1, SymR1, SymR1, SymR2};
      3'd4:    seq = {SymR1, SymS1, SymR1, SymS3};
      3'd5:    seq = {SymS1, SymR2, SymR2, SymS3};
      3'd6:    seq = {SymS1, SymR2, SymS3, SymS2};
      default: seq = {SymS1, SymS1, SymS1, SymS2};
    endcase
    return seq[5*(3-int'(idx)) +: 5];
  endfunction

  state_e            state_q, state_d;
  logic [SymW-1:0]   cnt_q, cnt_d;
  logic [NibW-1:0]   nib_q, nib_d, nib_inc;
  logic [2:0]        type_q, type_d;
  logic              err_seen_q, err_seen_d;
  logic              data_en_q, data_en_d;
  logic [4:0]        data_q, data_d;
  logic              pre_q, pre_d;
  logic              pl_done_q, pl_done_d;
  logic              tx_done_q, tx_done_d;
  logic              tx_err_q, tx_err_d;

  logic              done_acc, abort_acc, emit, word_end, bist_req;
  logic [NpwW-1:0]   nib_idx;
  logic [4:0]        sym;

`ifdef PHY_TX_BIST_EN
  localparam bit BistMode = 1'b1;
  assign bist_req = phy_tx_bist_en;
`else
  localparam bit BistMode = 1'b0;
  logic unused_bist;
  assign bist_req    = 1'b0;
  assign unused_bist = phy_tx_bist_en;
`endif

  assign done_acc  = data_en_q & phy_bmc_encoder_data_done;
  assign abort_acc = phy_tx_abort & (state_q != StIdle) & (state_q != StHold);
  assign emit      = (state_q == StPreamble) | (state_q == StSop) | (state_q == StPayload) |
                     (state_q == StCrc) | (state_q == StEop);
  assign nib_idx   = cnt_q[NpwW-1:0];
  assign word_end  = (nib_idx == NpwW'(NPW - 1));

  always_comb begin
    sym = 5'b00000;
    unique case (state_q)
      StSop:     sym = sop_sym(type_q, cnt_q[1:0]);
      StPayload: sym = enc_4b5b(pl2phy_tx_payload[4*int'(nib_idx) +: 4]);
      StCrc:     sym = enc_4b5b(phy_tx_packet_crc[4*int'(cnt_q) +: 4]);
      StEop:     sym = SymEop;
      default:   sym = 5'b00000;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    nib_d      = nib_q;
    nib_inc    = (nib_q == NibW'(MAX_NIB)) ? nib_q : nib_q + NibW'(1);
    type_d     = type_q;
    err_seen_d = err_seen_q;
    pl_done_d  = 1'b0;
    tx_done_d  = 1'b0;
    tx_err_d   = 1'b0;
    if (done_acc) cnt_d = cnt_q + SymW'(1);

    unique case (state_q)
      StIdle: begin
        if (phy_tx_packet_en || bist_req) state_d = StPreamble;
      end
      StPreamble: begin
        if (done_acc) begin
          if (bist_req) state_d = StPreamble;
          else if (phy_tx_packet_en || !BistMode) state_d = StSop;
          else state_d = StIdle;
        end
      end
      StSop: begin
        if (done_acc && cnt_q[1:0] == 2'd3) begin
          state_d = (type_q == 3'd3 || type_q == 3'd4) ? StHold : StPayload;
        end
      end
      StPayload: begin
        if (done_acc) begin
          nib_d = nib_inc;
          if (word_end) pl_done_d = 1'b1;
          // A final word landing exactly on the limit still gets its CRC and EOP.
          if (word_end && pl2phy_tx_payload_last) begin
            state_d = StCrc;
          end else if (nib_inc >= NibW'(MAX_NIB)) begin
            state_d    = StHold;
            tx_err_d   = 1'b1;
            err_seen_d = 1'b1;
          end
        end
      end
      StCrc: begin
        if (done_acc && cnt_q == SymW'(CRC_NIB - 1)) state_d = StEop;
      end
      StEop: begin
        if (done_acc) state_d = StHold;
      end
      StHold: begin
        if (phy_bmc_encoder_hold_lowbmc_done) begin
          state_d    = StIdle;
          tx_done_d  = ~err_seen_q;
          err_seen_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (abort_acc) begin
      state_d    = StHold;
      pl_done_d  = 1'b0;
      tx_err_d   = 1'b1;
      err_seen_d = 1'b1;
    end

    if (state_d != state_q) cnt_d = '0;
    if (state_d == StSop && state_q != StSop) begin
      nib_d  = '0;
      type_d = (phy_tx_packet_type == 3'd7) ? 3'd0 : phy_tx_packet_type;
    end
  end

  // Symbol launch: one idle cycle after every accepted done, payload held while valid.
  always_comb begin
    data_en_d = emit & ~done_acc & ~abort_acc;
    data_d    = 5'b00000;
    pre_d     = 1'b0;
    if (data_en_q && data_en_d) begin
      data_d = data_q;
      pre_d  = pre_q;
    end else if (data_en_d) begin
      data_d = sym;
      pre_d  = (state_q == StPreamble);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      nib_q      <= '0;
      type_q     <= 3'd0;
      err_seen_q <= 1'b0;
      data_en_q  <= 1'b0;
      data_q     <= 5'b00000;
      pre_q      <= 1'b0;
      pl_done_q  <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      nib_q      <= nib_d;
      type_q     <= type_d;
      err_seen_q <= err_seen_d;
      data_en_q  <= data_en_d;
      data_q     <= data_d;
      pre_q      <= pre_d;
      pl_done_q  <= pl_done_d;
      tx_done_q  <= tx_done_d;
      tx_err_q   <= tx_err_d;
    end
  end

  assign phy_bmc_encoder_data_en       = data_en_q;
  assign phy_bmc_encoder_data          = data_q;
  assign phy_bmc_encoder_data_preamble = pre_q;
  assign phy2pl_tx_payload_done        = pl_done_q;
  assign phy_tx_done                   = tx_done_q;
  assign phy_tx_err                    = tx_err_q;

endmodule
